// File: rtl/instruction_memory_pipelined.sv
// instruction_memory_pipelined: byte-addressed little-endian instruction memory with a registered,
// valid/ready fetch port, byte-enabled program-load write port, fault detection and a fetch counter.
module instruction_memory_pipelined #(
    parameter int          DEPTH_BYTES = 1024,
    parameter int          ADDR_WIDTH  = 64,
    parameter logic [31:0] NOP_WORD    = 32'h00000013,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_fault,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_be,
    output logic [CNT_WIDTH-1:0]  fetch_count
);
    localparam int AW = $clog2(DEPTH_BYTES);

    logic [31:0] mem [DEPTH_BYTES/4];
    logic        accept, mis, oor, wr_oor;
    logic        unused_wr_low;

    always_comb begin
        req_ready     = !resp_valid || resp_ready;
        accept        = req_valid && req_ready;
        mis           = |req_addr[1:0];
        oor           = |req_addr[ADDR_WIDTH-1:AW];
        wr_oor        = |wr_addr[ADDR_WIDTH-1:AW];
        unused_wr_low = ^wr_addr[1:0];
    end

    // Read-first: a same-edge write is not visible to the response captured on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_instr  <= '0;
            resp_addr   <= '0;
            resp_fault  <= 2'b00;
            fetch_count <= '0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_addr   <= req_addr;
            resp_fault  <= {oor, mis};
            resp_instr  <= (oor || mis) ? NOP_WORD : mem[req_addr[AW-1:2]];
            fetch_count <= fetch_count + CNT_WIDTH'(1);
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset && !wr_oor)
            for (int i = 0; i < 4; i++)
                if (wr_be[i]) mem[wr_addr[AW-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
    end
endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// tb_instruction_memory_pipelined: directed scenario tests for instruction_memory_pipelined.
module tb_instruction_memory_pipelined;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, resp_ready = 1'b0, wr_en = 1'b0;
    logic [63:0] req_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_instr;
    logic [63:0] resp_addr;
    logic [1:0]  resp_fault;
    logic [31:0] fetch_count;
    logic        req_ready4, resp_valid4;
    logic [31:0] resp_instr4;
    logic [63:0] resp_addr4;
    logic [1:0]  resp_fault4;
    logic [3:0]  fetch_count4;
    int total = 0, bad = 0;

    wire [98:0] resp_bus = {resp_valid, resp_fault, resp_addr, resp_instr};

    always #5 clk = ~clk;

    instruction_memory_pipelined dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr), .resp_addr(resp_addr),
        .resp_fault(resp_fault), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .fetch_count(fetch_count)
    );

    instruction_memory_pipelined #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4), .req_addr(req_addr),
        .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_instr(resp_instr4), .resp_addr(resp_addr4),
        .resp_fault(resp_fault4), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .fetch_count(fetch_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++;
        if ({resp_bus, fetch_count} !== {99'h0, 32'h0}) begin
            bad++; $display("FAIL reset_state: got %h/%h want 0/0", resp_bus, fetch_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        wr(64'h0, 32'h02853483, 4'hF);
        wr(64'h4, 32'h009A84B3, 4'hF);
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b00, 64'h0, 32'h02853483}) begin
            bad++; $display("FAIL fetch_0: got %h want %h", resp_bus, {1'b1, 2'b00, 64'h0, 32'h02853483});
        end
        req_addr = 64'h4;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b00, 64'h4, 32'h009A84B3}) begin
            bad++; $display("FAIL fetch_4: got %h want %h", resp_bus, {1'b1, 2'b00, 64'h4, 32'h009A84B3});
        end
        req_valid = 1'b0;
        tick();
        total++;
        if ({resp_bus, fetch_count} !== {1'b0, 2'b00, 64'h4, 32'h009A84B3, 32'd2}) begin
            bad++; $display("FAIL drain_hold: got %h/%0d want valid=0 fields held count=2", resp_bus, fetch_count);
        end
    endtask

    task automatic test_faults();
        wr(64'd1024, 32'hAAAAAAAA, 4'hF);
        req_valid = 1'b1; req_addr = 64'h6;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b01, 64'h6, 32'h00000013}) begin
            bad++; $display("FAIL misaligned: got %h want %h", resp_bus, {1'b1, 2'b01, 64'h6, 32'h00000013});
        end
        req_addr = 64'd1028;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b10, 64'd1028, 32'h00000013}) begin
            bad++; $display("FAIL out_of_range: got %h want %h", resp_bus, {1'b1, 2'b10, 64'd1028, 32'h00000013});
        end
        req_addr = 64'd1025;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b11, 64'd1025, 32'h00000013}) begin
            bad++; $display("FAIL both_faults: got %h want %h", resp_bus, {1'b1, 2'b11, 64'd1025, 32'h00000013});
        end
        req_addr = 64'h0;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b00, 64'h0, 32'h02853483}) begin
            bad++; $display("FAIL oor_write_dropped: got %h want %h", resp_bus, {1'b1, 2'b00, 64'h0, 32'h02853483});
        end
        req_valid = 1'b0;
        tick();
        total++;
        if (fetch_count !== 32'd6) begin bad++; $display("FAIL fault_count: got %0d want 6", fetch_count); end
    endtask

    task automatic test_backpressure();
        wr(64'h8, 32'hDEADBEEF, 4'hF);
        req_valid = 1'b1; req_addr = 64'h0;
        tick();
        resp_ready = 1'b0; req_addr = 64'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({req_ready, resp_bus} !== {1'b0, 1'b1, 2'b00, 64'h0, 32'h02853483}) begin
                bad++; $display("FAIL stall_%0d: got ready=%b %h want ready=0 stable", i, req_ready, resp_bus);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", req_ready); end
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b00, 64'h8, 32'hDEADBEEF}) begin
            bad++; $display("FAIL after_stall: got %h want %h", resp_bus, {1'b1, 2'b00, 64'h8, 32'hDEADBEEF});
        end
        req_valid = 1'b0;
        tick();
        total++;
        if ({resp_valid, fetch_count} !== {1'b0, 32'd8}) begin
            bad++; $display("FAIL stall_count: got valid=%b count=%0d want 0/8", resp_valid, fetch_count);
        end
    endtask

    task automatic test_partial_write();
        wr(64'h4, 32'hFFFFFFFF, 4'b0101);
        req_valid = 1'b1; req_addr = 64'h4;
        tick();
        total++;
        if (resp_instr !== 32'h00FF84FF) begin bad++; $display("FAIL partial_write: got %h want 00FF84FF", resp_instr); end
        wr_en = 1'b1; wr_addr = 64'h6; wr_data = 32'h12345678; wr_be = 4'hF;
        tick();
        wr_en = 1'b0;
        total++;
        if (resp_instr !== 32'h00FF84FF) begin bad++; $display("FAIL read_first: got %h want 00FF84FF", resp_instr); end
        tick();
        total++;
        if (resp_instr !== 32'h12345678) begin bad++; $display("FAIL after_write: got %h want 12345678", resp_instr); end
        req_valid = 1'b0;
        tick();
        total++;
        if (fetch_count !== 32'd11) begin bad++; $display("FAIL partial_count: got %0d want 11", fetch_count); end
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_addr = 64'h0;
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({resp_bus, fetch_count} !== {99'h0, 32'h0}) begin
            bad++; $display("FAIL async_reset: got %h/%0d want 0/0", resp_bus, fetch_count);
        end
        wr_en = 1'b1; wr_addr = 64'h8; wr_data = 32'h11111111; wr_be = 4'hF;
        tick();
        wr_en = 1'b0; reset = 1'b0; resp_ready = 1'b1;
        tick();
        req_valid = 1'b1; req_addr = 64'h0;
        tick();
        total++;
        if (resp_bus !== {1'b1, 2'b00, 64'h0, 32'h02853483}) begin
            bad++; $display("FAIL mem_retained: got %h want %h", resp_bus, {1'b1, 2'b00, 64'h0, 32'h02853483});
        end
        req_addr = 64'h8;
        tick();
        total++;
        if ({resp_instr, fetch_count} !== {32'hDEADBEEF, 32'd2}) begin
            bad++; $display("FAIL write_in_reset: got %h/%0d want DEADBEEF/2", resp_instr, fetch_count);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_counter_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h0;
        for (int i = 0; i < 17; i++) tick();
        req_valid = 1'b0;
        tick();
        total++;
        if ({fetch_count4, fetch_count} !== {4'd1, 32'd17}) begin
            bad++; $display("FAIL counter_wrap: got %0d/%0d want 1/17", fetch_count4, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_partial_write();
        test_async_reset();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
